// File: rtl/imm_gen_pipe_pkg.sv
// Shared definitions for the pipelined immediate generator: format encodings
// and the layout of one output-buffer entry.
package imm_pkg;

  localparam logic [2:0] EXT_I   = 3'd0;
  localparam logic [2:0] EXT_U   = 3'd1;
  localparam logic [2:0] EXT_S   = 3'd2;
  localparam logic [2:0] EXT_B   = 3'd3;
  localparam logic [2:0] EXT_J   = 3'd4;
  localparam logic [2:0] EXT_Z   = 3'd5;
  localparam logic [2:0] EXT_SH  = 3'd6;
  localparam logic [2:0] EXT_ILL = 3'd7;

  // Entries are sized for the widest legal XLEN; narrower builds use the low bits.
  localparam int IMM_MAX_W = 64;

  typedef struct packed {
    logic                 illegal;
    logic [31:0]          instr;
    logic [IMM_MAX_W-1:0] imm;
  } imm_entry_t;

endpackage

// File: rtl/imm_gen_pipe_extract.sv
// Combinational immediate extraction for all RISC-V immediate formats,
// sign- or zero-extended to XLEN.
module imm_extract
  import imm_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     instr,
  input  logic [2:0]      ext_op,
  output logic [XLEN-1:0] imm,
  output logic            illegal
);

  localparam int SH_W = (XLEN == 64) ? 6 : 5;

  logic [11:0] w_i_raw;
  logic [31:0] w_u_raw;
  logic [11:0] w_s_raw;
  logic [12:0] w_b_raw;
  logic [20:0] w_j_raw;
  logic        w_unused;

  assign w_i_raw = instr[31:20];
  assign w_u_raw = {instr[31:12], 12'b0};
  assign w_s_raw = {instr[31:25], instr[11:7]};
  assign w_b_raw = {instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  assign w_j_raw = {instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
  // The major opcode never contributes to an immediate.
  assign w_unused = ^instr[6:0];

  // Format mux; the reserved encoding yields zero and flags the request.
  always_comb begin
    imm     = {XLEN{1'b0}};
    illegal = 1'b0;
    case (ext_op)
      EXT_I:   imm = XLEN'($signed(w_i_raw));
      EXT_U:   imm = XLEN'($signed(w_u_raw));
      EXT_S:   imm = XLEN'($signed(w_s_raw));
      EXT_B:   imm = XLEN'($signed(w_b_raw));
      EXT_J:   imm = XLEN'($signed(w_j_raw));
      EXT_Z:   imm = XLEN'(instr[19:15]);
      EXT_SH:  imm = XLEN'(instr[19+SH_W:20]);
      EXT_ILL: illegal = 1'b1;
      default: begin
        imm     = {XLEN{1'b0}};
        illegal = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/imm_gen_pipe.sv
// Decode-side immediate generator with a small circular output buffer so that
// decode can keep issuing while execute stalls; also counts illegal requests.
module imm_gen_pipe
  import imm_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int DEPTH = 2,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      instr,
  input  logic [2:0]       ext_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  imm,
  output logic [31:0]      out_instr,
  output logic             out_illegal,
  output logic [CNT_W-1:0] illegal_cnt
);

  localparam int             PTR_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W:0] FULL_CNT  = (PTR_W + 1)'(DEPTH);
  localparam logic [PTR_W:0] EMPTY_CNT = {(PTR_W + 1){1'b0}};

  imm_entry_t       r_buf [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W:0]   r_count;
  logic [CNT_W-1:0] r_ill_cnt;

  logic [XLEN-1:0]  w_imm;
  logic             w_illegal;
  logic             w_push;
  logic             w_pop;
  imm_entry_t       w_head;
  logic             w_unused;

  imm_extract #(
    .XLEN (XLEN)
  ) u_extract (
    .instr   (instr),
    .ext_op  (ext_op),
    .imm     (w_imm),
    .illegal (w_illegal)
  );

  // Readiness comes from registered occupancy only, never from out_ready.
  assign in_ready  = (r_count != FULL_CNT);
  assign out_valid = (r_count != EMPTY_CNT);
  assign w_push    = in_valid && in_ready;
  assign w_pop     = out_valid && out_ready;

  assign w_head      = r_buf[r_rd_ptr];
  assign imm         = w_head.imm[XLEN-1:0];
  assign out_instr   = w_head.instr;
  assign out_illegal = w_head.illegal;
  assign illegal_cnt = r_ill_cnt;
  assign w_unused    = ^w_head.imm;

  // Circular buffer storage, pointers and occupancy; flush wins over push/pop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= {PTR_W{1'b0}};
      r_rd_ptr <= {PTR_W{1'b0}};
      r_count  <= EMPTY_CNT;
      for (int i = 0; i < DEPTH; i++) begin
        r_buf[i] <= '0;
      end
    end else if (flush) begin
      r_wr_ptr <= {PTR_W{1'b0}};
      r_rd_ptr <= {PTR_W{1'b0}};
      r_count  <= EMPTY_CNT;
    end else begin
      if (w_push) begin
        r_buf[r_wr_ptr] <= '{illegal: w_illegal,
                             instr:   instr,
                             imm:     IMM_MAX_W'(w_imm)};
        r_wr_ptr        <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (PTR_W + 1)'(1);
        2'b01:   r_count <= r_count - (PTR_W + 1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Saturating illegal-request counter; a flushed request was never accepted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ill_cnt <= {CNT_W{1'b0}};
    end else if (w_push && w_illegal && !flush && (r_ill_cnt != {CNT_W{1'b1}})) begin
      r_ill_cnt <= r_ill_cnt + CNT_W'(1);
    end else begin
      r_ill_cnt <= r_ill_cnt;
    end
  end

endmodule
